windowed_regfile: RTL

Decode-stage register file with register windows for the 16-bit pipeline. It drives the A/B operands and current window number straight into the ID/EX pipeline register, and takes the write-back port from the last stage. Call/return instructions rotate the window pointer. A small clear engine zeroes the locals of each newly entered window, stalling decode while it runs. Window overflow and underflow are flagged for the exception logic.

---
 rtl/windowed_regfile_if.sv | 33 +++
 rtl/windowed_regfile.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/windowed_regfile_if.sv
// Decode/write-back port bundle for windowed_regfile: operand reads, write-back,
// window call/return controls and the stall/exception flags.
interface windowed_regfile_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NWIN   = 4
);
  localparam int unsigned WinW = (NWIN > 1) ? $clog2(NWIN) : 1;

  logic [2:0]        rd_addr_a;
  logic [2:0]        rd_addr_b;
  logic [DATA_W-1:0] rega;
  logic [DATA_W-1:0] regb;
  logic [WinW-1:0]   window_r;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [WinW-1:0]   wr_win;
  logic [DATA_W-1:0] wr_data;
  logic              win_inc;
  logic              win_dec;
  logic              stall;
  logic              win_ovf;
  logic              win_unf;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_win, wr_data, win_inc, win_dec,
    input  rega, regb, window_r, stall, win_ovf, win_unf
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_win, wr_data, win_inc, win_dec,
    output rega, regb, window_r, stall, win_ovf, win_unf
  );
endinterface

// File: rtl/windowed_regfile.sv
// Windowed decode register file: r0 zero, r1-r3 global, r4-r7 per-window locals, with a
// clear engine for newly entered windows. Define WRF_BYPASS_EN for write-to-read bypass.
module windowed_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NWIN   = 4
) (
  input logic             clk,
  input logic             rst,
  windowed_regfile_if.slave bus
);
  localparam int unsigned WinW  = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int unsigned NPhys = 3 + 4 * NWIN;
  localparam int unsigned PhysW = $clog2(NPhys);
  localparam logic [WinW-1:0] DepthMax = WinW'(NWIN - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // Globals occupy entries 0..2, window w's locals follow at 3 + 4*w.
  function automatic logic [PhysW-1:0] phys_idx(input logic [2:0] addr,
                                                input logic [WinW-1:0] win);
    logic [PhysW-1:0] idx;
    if (addr[2]) begin
      idx = PhysW'(3) + PhysW'({win, addr[1:0]});
    end else begin
      idx = PhysW'(addr) - PhysW'(1);
    end
    return idx;
  endfunction

  state_e            r_state;
  state_e            w_state_next;
  logic [WinW-1:0]   r_cwp;
  logic [WinW-1:0]   r_depth;
  logic [1:0]        r_clr_idx;
  logic              r_ovf;
  logic              r_unf;
  logic [DATA_W-1:0] r_mem [NPhys];

  logic [PhysW-1:0]  w_rd_idx_a;
  logic [PhysW-1:0]  w_rd_idx_b;
  logic [PhysW-1:0]  w_wr_idx;
  logic [PhysW-1:0]  w_clr_phys;
  logic              w_wr_act;
  logic              w_inc_req;
  logic              w_dec_req;
  logic              w_inc_ok;
  logic              w_dec_ok;
  logic              w_ovf_d;
  logic              w_unf_d;
  logic              w_stall;
  logic              w_clr_en;
  logic              w_byp_a;
  logic              w_byp_b;
  logic [DATA_W-1:0] w_rega;
  logic [DATA_W-1:0] w_regb;

  assign w_rd_idx_a = phys_idx(bus.rd_addr_a, r_cwp);
  assign w_rd_idx_b = phys_idx(bus.rd_addr_b, r_cwp);
  assign w_wr_idx   = phys_idx(bus.wr_addr, bus.wr_win);
  assign w_clr_phys = phys_idx({1'b1, r_clr_idx}, r_cwp);
  assign w_wr_act   = bus.wr_en && (bus.wr_addr != 3'd0);

  assign w_inc_req = (r_state == StIdle) && bus.win_inc && !bus.win_dec;
  assign w_dec_req = (r_state == StIdle) && bus.win_dec && !bus.win_inc;
  assign w_inc_ok  = w_inc_req && (r_depth != DepthMax);
  assign w_dec_ok  = w_dec_req && (r_depth != '0);
  assign w_ovf_d   = w_inc_req && (r_depth == DepthMax);
  assign w_unf_d   = w_dec_req && (r_depth == '0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_inc_ok) w_state_next = StClear;
      StClear: if (r_clr_idx == 2'd3) w_state_next = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_stall  = 1'b0;
    w_clr_en = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StClear: begin
        w_stall  = 1'b1;
        w_clr_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cwp     <= '0;
      r_depth   <= '0;
      r_clr_idx <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_ovf <= w_ovf_d;
      r_unf <= w_unf_d;
      if (w_inc_ok) begin
        r_cwp     <= r_cwp + WinW'(1);
        r_depth   <= r_depth + WinW'(1);
        r_clr_idx <= '0;
      end else if (w_dec_ok) begin
        r_cwp   <= r_cwp - WinW'(1);
        r_depth <= r_depth - WinW'(1);
      end
      if (w_clr_en) r_clr_idx <= r_clr_idx + 2'd1;
    end
  end

  // The write is issued after the clear so it wins on a shared entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPhys; i++) r_mem[i] <= '0;
    end else begin
      if (w_clr_en) r_mem[w_clr_phys] <= '0;
      if (w_wr_act) r_mem[w_wr_idx] <= bus.wr_data;
    end
  end

`ifdef WRF_BYPASS_EN
  // Physical-index match already accounts for wr_win vs cwp on locals.
  assign w_byp_a = w_wr_act && (w_wr_idx == w_rd_idx_a);
  assign w_byp_b = w_wr_act && (w_wr_idx == w_rd_idx_b);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  always_comb begin
    w_rega = r_mem[w_rd_idx_a];
    if (w_byp_a) w_rega = bus.wr_data;
    if (bus.rd_addr_a == 3'd0) w_rega = '0;
    w_regb = r_mem[w_rd_idx_b];
    if (w_byp_b) w_regb = bus.wr_data;
    if (bus.rd_addr_b == 3'd0) w_regb = '0;
  end

  assign bus.rega     = w_rega;
  assign bus.regb     = w_regb;
  assign bus.window_r = r_cwp;
  assign bus.stall    = w_stall;
  assign bus.win_ovf  = r_ovf;
  assign bus.win_unf  = r_unf;
endmodule
